// File: rtl/bus_pkg.sv
// Shared definitions for the m2/s3 serial bus: slave FSM states, rw encoding
// and the default frame field widths used by masters, bus and slaves.
package bus_pkg;

    localparam int BUS_ADDR_W = 4;
    localparam int BUS_DATA_W = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDWAIT,
        S_RDATA,
        S_DONE
    } slave_state_e;

endpackage

// File: rtl/slave_regfile.sv
// Slave-local register memory: single-port RAM with synchronous write and a
// registered read; out-of-range writes are dropped and out-of-range reads return 0.
module slave_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    logic          inRange;

    assign inRange = int'(addr_i) < DEPTH;
    assign rdata_o = rdata_q;

    // Read data is held between read strobes so the port can serialise it.
    always_ff @(posedge clk) begin
        if (we_i && inRange) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= inRange ? mem[addr_i] : '0;
        end
    end

endmodule

// File: rtl/bus_slave_port.sv
// Slave end of the serial bus: deserialises rw/address/write-data frames,
// accesses the local register file and serialises read data back, MSB first.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_W    = BUS_ADDR_W,
    parameter int DATA_W    = BUS_DATA_W,
    parameter int MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_valid,
    input  logic              bus_wdata,
    output logic              bus_ready,
    output logic              bus_rdata,
    output logic              bus_rvalid,
    output logic              bus_done,
    output logic              frame_err,
    input  logic              busy,
    output logic [DATA_W-1:0] last_wdata
);

    localparam int CNT_W = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

    slave_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-2:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rshift_q, rshift_d;
    logic [DATA_W-1:0] lastWdata_q, lastWdata_d;
    logic              err_q, err_d;

    logic              memWe, memRe;
    logic [DATA_W-1:0] memRdata;
    logic [DATA_W-1:0] wordIn;
    logic              addrOk, lastAddr, lastData;

    assign wordIn    = {wdata_q, bus_wdata};
    assign addrOk    = int'(addr_q) < MEM_DEPTH;
    assign lastAddr  = cnt_q == CNT_W'(ADDR_W - 1);
    assign lastData  = cnt_q == CNT_W'(DATA_W - 1);
    assign frame_err = err_q;
    assign last_wdata = lastWdata_q;

    slave_regfile #(
        .DEPTH(MEM_DEPTH),
        .AW   (ADDR_W),
        .DW   (DATA_W)
    ) u_regfile (
        .clk    (clk),
        .we_i   (memWe),
        .re_i   (memRe),
        .addr_i (addr_q),
        .wdata_i(wordIn),
        .rdata_o(memRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            rshift_q    <= '0;
            lastWdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rshift_q    <= rshift_d;
            lastWdata_q <= lastWdata_d;
            err_q       <= err_d;
        end
    end

    // The counter only advances while a field is being shifted and is zero on every state change.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rshift_d    = rshift_q;
        lastWdata_d = lastWdata_q;
        err_d       = 1'b0;
        memWe       = 1'b0;
        memRe       = 1'b0;
        bus_ready   = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = 1'b0;
        bus_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus_ready = !busy;
                if (bus_valid && !busy) begin
                    rw_d    = bus_wdata;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!bus_valid) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = {addr_q[ADDR_W-2:0], bus_wdata};
                    if (lastAddr) begin
                        state_d = (rw_q == RW_WRITE) ? S_WDATA : S_RDWAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (!bus_valid) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdata_d = wordIn[DATA_W-2:0];
                    if (lastData) begin
                        memWe   = addrOk;
                        state_d = S_DONE;
                        if (addrOk) begin
                            lastWdata_d = wordIn;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RDWAIT: begin
                if (!bus_valid) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (!busy) begin
                    memRe   = 1'b1;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                // First bit comes straight from the RAM output, the rest from the shifter.
                if (!bus_valid) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    bus_rvalid = 1'b1;
                    if (cnt_q == '0) begin
                        bus_rdata = memRdata[DATA_W-1];
                        rshift_d  = {memRdata[DATA_W-2:0], 1'b0};
                    end else begin
                        bus_rdata = rshift_q[DATA_W-1];
                        rshift_d  = {rshift_q[DATA_W-2:0], 1'b0};
                    end
                    if (lastData) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                bus_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: serial write/read frames, busy hold-off,
// aborted frames, out-of-range addresses and reset in the middle of a read.
module tb_bus_slave_port;

    logic       clk;
    logic       rst;
    logic       bus_valid;
    logic       bus_wdata;
    logic       bus_ready;
    logic       bus_rdata;
    logic       bus_rvalid;
    logic       bus_done;
    logic       frame_err;
    logic       busy;
    logic [7:0] last_wdata;

    int checks;
    int errors;

    bus_slave_port #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .MEM_DEPTH(12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_valid (bus_valid),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .bus_done  (bus_done),
        .frame_err (frame_err),
        .busy      (busy),
        .last_wdata(last_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here so the counts stay consistent.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one bus cycle and returns just after the clock edge that consumes it.
    task automatic applyStimulus(input logic v, input logic b);
        bus_valid = v;
        bus_wdata = b;
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [3:0] a, input logic [7:0] d, input logic [7:0] expLast,
                           input int preBusy, input string tag);
        if (preBusy > 0) begin
            busy = 1'b1;
            for (int k = 0; k < preBusy; k++) begin
                applyStimulus(1'b1, 1'b0);
                checkOutput({tag, ":busyReady"}, bus_ready, 0);
                checkOutput({tag, ":busyErr"}, frame_err, 0);
            end
            busy = 1'b0;
            #1;
            checkOutput({tag, ":readyAfterBusy"}, bus_ready, 1);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput({tag, ":readyInFrame"}, bus_ready, 0);
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, a[i]);
        for (int i = 7; i >= 0; i--) applyStimulus(1'b1, d[i]);
        bus_valid = 1'b0;
        #1;
        checkOutput({tag, ":done"}, bus_done, 1);
        checkOutput({tag, ":lastWdata"}, last_wdata, expLast);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, ":doneOff"}, bus_done, 0);
        checkOutput({tag, ":readyBack"}, bus_ready, 1);
    endtask

    task automatic doRead(input logic [3:0] a, input logic [7:0] expData, input int holdCycles,
                          input int stopAfter, input string tag);
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, ":readyInFrame"}, bus_ready, 0);
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, a[i]);
        if (holdCycles > 0) begin
            busy = 1'b1;
            for (int k = 0; k < holdCycles; k++) begin
                applyStimulus(1'b1, 1'b0);
                checkOutput({tag, ":heldRvalid"}, bus_rvalid, 0);
            end
            busy = 1'b0;
        end
        #1;
        checkOutput({tag, ":rdwaitRvalid"}, bus_rvalid, 0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            if (7 - i == stopAfter) return;
            checkOutput({tag, ":rvalid"}, bus_rvalid, 1);
            checkOutput({tag, ":rdata"}, bus_rdata, expData[i]);
            applyStimulus(1'b1, 1'b0);
        end
        bus_valid = 1'b0;
        #1;
        checkOutput({tag, ":done"}, bus_done, 1);
        checkOutput({tag, ":rvalidOff"}, bus_rvalid, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, ":doneOff"}, bus_done, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus_valid = 1'b0;
        bus_wdata = 1'b0;
        busy      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset:rvalid", bus_rvalid, 0);
        checkOutput("reset:done", bus_done, 0);
        checkOutput("reset:err", frame_err, 0);
        checkOutput("reset:lastWdata", last_wdata, 0);
        checkOutput("reset:ready", bus_ready, 1);

        $display("[TB] write 0xA5 to addr 3, read it back");
        doWrite(4'd3, 8'hA5, 8'hA5, 0, "wr3");
        doRead(4'd3, 8'hA5, 0, -1, "rd3");

        $display("[TB] frame start held off by busy");
        doWrite(4'd7, 8'h5A, 8'h5A, 3, "busyWr7");
        doRead(4'd7, 8'h5A, 0, -1, "rd7");

        $display("[TB] read held in RDWAIT by busy");
        doRead(4'd3, 8'hA5, 4, -1, "busyRd3");

        $display("[TB] aborted write to addr 5");
        doWrite(4'd5, 8'h77, 8'h77, 0, "wr5");
        applyStimulus(1'b1, 1'b1);
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, i[0] ? 1'b0 : 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort:err", frame_err, 1);
        checkOutput("abort:done", bus_done, 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort:errOff", frame_err, 0);
        checkOutput("abort:lastWdata", last_wdata, 8'h77);
        doRead(4'd5, 8'h77, 0, -1, "rd5");

        $display("[TB] out-of-range address 14");
        doWrite(4'd14, 8'h3C, 8'h77, 0, "wr14");
        doRead(4'd14, 8'h00, 0, -1, "rd14");

        $display("[TB] reset during read data");
        doRead(4'd3, 8'hA5, 0, 3, "rstRd3");
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rstMid:rvalid", bus_rvalid, 0);
        checkOutput("rstMid:rdata", bus_rdata, 0);
        checkOutput("rstMid:done", bus_done, 0);
        checkOutput("rstMid:err", frame_err, 0);
        checkOutput("rstMid:lastWdata", last_wdata, 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("rstMid:errAfter", frame_err, 0);
        doWrite(4'd9, 8'hC3, 8'hC3, 0, "wr9");
        doRead(4'd9, 8'hC3, 0, -1, "rd9");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
